// File: rtl/seq_mult_ctrl.sv
// Shift-add unsigned multiplier: one partial-product bit per clock, WIDTH cycles per operation.
// Valid/ready on both sides; operands accepted only in IDLE, product held in DONE until taken.
module seq_mult_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH:0]   acc;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CNT_W-1:0] count;
    logic             accept;

    assign accept = (state == IDLE) && in_valid && !clear;
    assign sum    = acc + (mplier[0] ? {1'b0, mcand} : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (count == LAST) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Abort wins over every transition, including acceptance in IDLE.
        if (clear) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
        end else if (clear) begin
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand  <= a;
                        mplier <= b;
                        acc    <= '0;
                        count  <= '0;
                    end
                end
                RUN: begin
                    // Low product bits shift into the spent multiplier positions.
                    {acc, mplier} <= {sum, mplier} >> 1;
                    count         <= count + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign product   = {acc[WIDTH-1:0], mplier};

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed and randomised checks of seq_mult_ctrl at WIDTH=4 and WIDTH=8.
module tb_seq_mult_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  a = '0;
    logic [3:0]  b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  product;
    logic        busy;

    logic        clear8 = 1'b0;
    logic        in_valid8 = 1'b0;
    logic        in_ready8;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        out_valid8;
    logic        out_ready8 = 1'b0;
    logic [15:0] product8;
    logic        busy8;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_mult_ctrl #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .product(product), .busy(busy)
    );

    seq_mult_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .clear(clear8), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8), .product(product8), .busy(busy8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One full WIDTH=4 transaction; ign keeps in_valid high with 2*2 while the op is in flight.
    task automatic run_op(input logic [3:0] ta, input logic [3:0] tbv, input logic [7:0] exp,
                          input int stall, input bit ign, input string tag);
        int n;
        logic [7:0] held;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".rdy"}, in_ready, 1);
        a = ta;
        b = tbv;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = ign;
        a = ign ? 4'd2 : ~ta;
        b = ign ? 4'd2 : ~tbv;
        check({tag, ".acc_rdy"}, in_ready, 0);
        n = 1;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".lat"}, n, 5);
        check({tag, ".prod"}, product, exp);
        held = product;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check({tag, ".hold_vld"}, out_valid, 1);
            check({tag, ".hold_prod"}, product, held);
        end
        out_ready = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ".drop"}, out_valid, 0);
        check({tag, ".idle"}, in_ready, 1);
    endtask

    initial begin
        // Asynchronous reset asserted between clock edges.
        #7 rst = 1'b1;
        #1;
        check("rst.in_ready", in_ready, 1);
        check("rst.out_valid", out_valid, 0);
        check("rst.busy", busy, 0);
        check("rst.product", product, 0);
        check("rst.product8", product8, 0);
        @(negedge clk);
        rst = 1'b0;

        run_op(4'd3, 4'd3, 8'h09, 0, 1'b0, "basic");
        run_op(4'd15, 4'd15, 8'hE1, 0, 1'b0, "max");
        run_op(4'd0, 4'd13, 8'h00, 0, 1'b0, "zero");
        run_op(4'd1, 4'd15, 8'h0F, 1, 1'b0, "one");
        run_op(4'd10, 4'd6, 8'h3C, 0, 1'b0, "ten_six");
        run_op(4'd6, 4'd7, 8'h2A, 3, 1'b1, "bp_ign");

        // Abort on the second RUN cycle.
        @(negedge clk);
        a = 4'd7; b = 4'd5; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("abort.in_ready", in_ready, 1);
        check("abort.busy", busy, 0);
        begin
            bit seen = 1'b0;
            repeat (8) begin
                @(negedge clk);
                if (out_valid) seen = 1'b1;
            end
            check("abort.no_valid", seen, 0);
        end

        // Clear beats acceptance in IDLE.
        clear = 1'b1; in_valid = 1'b1; a = 4'd3; b = 4'd3;
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        check("clr_acc.in_ready", in_ready, 1);
        check("clr_acc.busy", busy, 0);

        run_op(4'd7, 4'd5, 8'h23, 0, 1'b0, "after_abort");

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        a = 4'd15; b = 4'd15; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_run.in_ready", in_ready, 1);
        check("rst_run.busy", busy, 0);
        check("rst_run.product", product, 0);
        @(negedge clk);
        rst = 1'b0;
        begin
            bit seen = 1'b0;
            repeat (8) begin
                @(negedge clk);
                if (out_valid) seen = 1'b1;
            end
            check("rst_run.no_valid", seen, 0);
        end

        for (int i = 0; i < 200; i++) begin
            logic [3:0] ra;
            logic [3:0] rb;
            logic [7:0] ex;
            ra = 4'($urandom);
            rb = 4'($urandom);
            ex = 8'(ra) * 8'(rb);
            run_op(ra, rb, ex, $urandom_range(0, 3), 1'b0, "rnd4");
        end

        for (int i = 0; i < 200; i++) begin
            logic [7:0]  ra;
            logic [7:0]  rb;
            logic [15:0] ex;
            logic [15:0] held;
            int st;
            int n;
            ra = 8'($urandom);
            rb = 8'($urandom);
            st = $urandom_range(0, 3);
            ex = 16'(ra) * 16'(rb);
            @(negedge clk);
            a8 = ra; b8 = rb; in_valid8 = 1'b1;
            @(negedge clk);
            in_valid8 = 1'b0;
            a8 = ~ra; b8 = ~rb;
            n = 1;
            while (!out_valid8 && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("rnd8.lat", n, 9);
            check("rnd8.prod", product8, ex);
            held = product8;
            repeat (st) @(negedge clk);
            if (st > 0) check("rnd8.hold_prod", product8, held);
            out_ready8 = 1'b1;
            @(negedge clk);
            out_ready8 = 1'b0;
            check("rnd8.drop", out_valid8, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
